seq_divider: RTL and testbench

- Unsigned sequential restoring divider; the inverse datapath of the team's shift-add sequential multiplier.
- Retires one quotient bit per clock using a trial-subtract / restore step.
- Operands arrive on a valid/ready source interface; results leave on a valid/ready destination interface.
- Sits beside the multiplier in the arithmetic unit and shares its operand-width parameter.

---
 rtl/div_pkg.sv | 24 ++
 rtl/trial_subtract.sv | 21 ++
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared types and constants for the sequential restoring divider
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient reported for a zero divisor; callers slice it to their width.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trial_subtract.sv
// ---------------------------------------------------------------------------
// trial_subtract : combinational minuend - subtrahend with borrow-out
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module trial_subtract #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    // The extra top bit of the zero-extended subtraction is the borrow.
    assign {borrow_out, difference} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider : unsigned restoring divider, one quotient bit per clock
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH_M = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [WIDTH_M-1:0] dividend,
    input  logic [WIDTH_M-1:0] divisor,
    output logic               dst_valid,
    input  logic               dst_ready,
    output logic [WIDTH_M-1:0] quotient,
    output logic [WIDTH_M-1:0] remainder,
    output logic               div_by_zero
);

    localparam int               CNT_W = cnt_width(WIDTH_M);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH_M - 1);

    state_e             state;
    logic [WIDTH_M-1:0] q_reg;
    logic [WIDTH_M-1:0] d_reg;
    logic [WIDTH_M:0]   r_reg;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH_M:0]   r_shift;
    logic [WIDTH_M:0]   trial;
    logic               borrow;

    // {R,Q} shifted left: the quotient MSB moves into the remainder LSB.
    assign r_shift = (r_reg << 1) | {{WIDTH_M{1'b0}}, q_reg[WIDTH_M-1]};

    trial_subtract #(
        .WIDTH (WIDTH_M + 1)
    ) u_trial_subtract (
        .minuend    (r_shift),
        .subtrahend ({1'b0, d_reg}),
        .difference (trial),
        .borrow_out (borrow)
    );

    assign quotient  = q_reg;
    assign remainder = r_reg[WIDTH_M-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            src_ready   <= 1'b0;
            dst_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    src_ready <= 1'b1;
                    if (src_valid && src_ready) begin
                        src_ready <= 1'b0;
                        d_reg     <= divisor;
                        cnt       <= '0;
                        if (divisor == '0) begin
                            q_reg       <= DIV0_QUOTIENT[WIDTH_M-1:0];
                            r_reg       <= {1'b0, dividend};
                            div_by_zero <= 1'b1;
                            dst_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_reg <= {q_reg[WIDTH_M-2:0], ~borrow};
                    r_reg <= borrow ? r_shift : trial;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        dst_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (dst_ready) begin
                        dst_valid <= 1'b0;
                        src_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider : directed and random self-checking bench for seq_divider
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        dst_valid;
    logic        dst_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(
        .WIDTH_M (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .dst_valid   (dst_valid),
        .dst_ready   (dst_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        src_valid = 1'b1;
        dividend  = a;
        divisor   = b;
        while (src_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (src_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout src_ready=%b required=1", src_ready);
        end
        @(negedge clk);
        src_valid = 1'b0;
        dividend  = 16'hDEAD;
        divisor   = 16'h0000;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (dst_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        src_valid = 1'b0;
        dividend  = '0;
        divisor   = '0;
        dst_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({src_ready, dst_valid, quotient, remainder, div_by_zero} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b q=%h r=%h dz=%b required all 0",
                     src_ready, dst_valid, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (src_ready !== 1'b1 || dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got rdy=%b vld=%b required rdy=1 vld=0", src_ready, dst_valid);
        end
    endtask

    task automatic test_basic();
        int k;
        send(16'd100, 16'd7);
        wait_valid(k);
        total++;
        if (k !== 16) begin
            bad++;
            $display("FAIL basic_latency got=%0d required=16", k);
        end
        total++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL basic_result got q=%0d r=%0d dz=%b required q=14 r=2 dz=0",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        total++;
        if (dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_single_result dst_valid=%b required=0", dst_valid);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        send(16'hFFFF, 16'd1);
        wait_valid(k);
        total++;
        if (quotient !== 16'hFFFF || remainder !== 16'd0) begin
            bad++;
            $display("FAIL b2b_first got q=%h r=%h required q=ffff r=0", quotient, remainder);
        end
        src_valid = 1'b1;
        dividend  = 16'd3;
        divisor   = 16'd10;
        @(negedge clk);
        total++;
        if (dst_valid !== 1'b0 || src_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle_gap got vld=%b rdy=%b required vld=0 rdy=1", dst_valid, src_ready);
        end
        @(negedge clk);
        src_valid = 1'b0;
        total++;
        if (src_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_accept src_ready=%b required=0", src_ready);
        end
        wait_valid(k);
        total++;
        if (k !== 16 || quotient !== 16'd0 || remainder !== 16'd3) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d q=%0d r=%0d required lat=16 q=0 r=3",
                     k, quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int k;
        send(16'd5, 16'd0);
        wait_valid(k);
        total++;
        if (k !== 0) begin
            bad++;
            $display("FAIL div0_latency got=%0d required=0 extra cycles", k);
        end
        total++;
        if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
            bad++;
            $display("FAIL div0_result got q=%h r=%0d dz=%b required q=ffff r=5 dz=1",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        send(16'd9, 16'd3);
        wait_valid(k);
        total++;
        if (quotient !== 16'd3 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL div0_clear got q=%0d r=%0d dz=%b required q=3 r=0 dz=0",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int k;
        dst_ready = 1'b0;
        send(16'd1000, 16'd33);
        wait_valid(k);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dst_valid !== 1'b1 || src_ready !== 1'b0 || quotient !== 16'd30 ||
                remainder !== 16'd10 || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b q=%0d r=%0d dz=%b required vld=1 rdy=0 q=30 r=10 dz=0",
                         i, dst_valid, src_ready, quotient, remainder, div_by_zero);
            end
            @(negedge clk);
        end
        dst_ready = 1'b1;
        @(negedge clk);
        total++;
        if (dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release dst_valid=%b required=0", dst_valid);
        end
    endtask

    task automatic test_reset_abort();
        int k;
        bit seen;
        send(16'hABCD, 16'h0012);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({src_ready, dst_valid, quotient, remainder, div_by_zero} !== 35'd0) begin
            bad++;
            $display("FAIL abort_async got rdy=%b vld=%b q=%h r=%h dz=%b required all 0",
                     src_ready, dst_valid, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (dst_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_result dst_valid seen=%b required=0", seen);
        end
        send(16'hABCD, 16'h0012);
        wait_valid(k);
        total++;
        if (quotient !== 16'h098B || remainder !== 16'h0007) begin
            bad++;
            $display("FAIL abort_fresh got q=%h r=%h required q=098b r=0007", quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int k;
        logic [15:0] a, b, eq, er;
        logic        edz;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 15));
                3:       b = 16'($urandom_range(16, 255));
                default: b = 16'($urandom);
            endcase
            if (b == 16'd0) begin
                eq = 16'hFFFF; er = a; edz = 1'b1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0;
            end
            send(a, b);
            wait_valid(k);
            total++;
            if (dst_valid !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
                bad++;
                $display("FAIL rand a=%h b=%h got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                         a, b, quotient, remainder, div_by_zero, eq, er, edz);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
